// File: rtl/spi_master_pkg.sv
// rtl/spi_master_pkg.sv - shared state encoding, SPI mode constants and sizing helpers
package spi_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // {cpol, cpha}
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  function automatic int cs_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/spi_edge_gen.sv
// rtl/spi_edge_gen.sv - SCLK divider: flags the SCLK edge taken at the next clk edge
module spi_edge_gen #(
  parameter int N_BIT   = 96,
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic nrst,
  input  logic start,
  input  logic run,
  output logic edge_stb,
  output logic lead,
  output logic last,
  output logic shift_end
);

  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int EW = $clog2(2 * N_BIT + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [EW-1:0] EDGES    = EW'(2 * N_BIT);

  logic [DW-1:0] div;
  logic [EW-1:0] edge_cnt;
  logic [EW-1:0] edge_num;
  logic          tick;

  // start fires edge 1 itself; later edges come every CLK_DIV cycles, and one
  // more full period elapses after edge 2*N_BIT before the shift phase ends
  always_comb begin
    tick      = run && (div == DIV_LAST);
    edge_stb  = start || (tick && (edge_cnt != EDGES));
    edge_num  = start ? EW'(1) : edge_cnt + 1'b1;
    lead      = edge_num[0];
    last      = (edge_num == EDGES);
    shift_end = tick && (edge_cnt == EDGES);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      div      <= '0;
      edge_cnt <= '0;
    end else if (start) begin
      div      <= '0;
      edge_cnt <= EW'(1);
    end else if (run) begin
      div <= tick ? '0 : div + 1'b1;
      if (edge_stb) edge_cnt <= edge_num;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// rtl/spi_master_multi.sv - multi-CS SPI master with per-frame mode, CS timing and MISO readback
module spi_master_multi import spi_master_pkg::*; #(
  parameter int N_BIT    = 96,
  parameter int NUM_CS   = 2,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 4
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          pll_locked,
  input  logic                          wreq,
  input  logic [N_BIT-1:0]              wdata,
  input  logic [cs_width(NUM_CS)-1:0]   cs_sel,
  input  logic                          cpol,
  input  logic                          cpha,
  output logic                          rdy,
  output logic                          done,
  output logic                          err,
  output logic [N_BIT-1:0]              rdata,
  output logic                          spi_sclk,
  output logic [NUM_CS-1:0]             spi_csn,
  output logic                          spi_mosi,
  input  logic                          spi_miso
);

  localparam int CW = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [N_BIT-1:0] tx, rx, tx_shl, rx_shl;
  logic             cpol_q, cpha_q;
  logic             accept, reject, abort, setup_last, hold_last;
  logic             edge_stb, lead, last, shift_end;

  spi_edge_gen #(.N_BIT(N_BIT), .CLK_DIV(CLK_DIV)) u_edge_gen (
    .clk       (clk),
    .nrst      (nrst),
    .start     (setup_last),
    .run       ((state == ST_SHIFT) && pll_locked),
    .edge_stb  (edge_stb),
    .lead      (lead),
    .last      (last),
    .shift_end (shift_end)
  );

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    reject     = 1'b0;
    abort      = 1'b0;
    setup_last = 1'b0;
    hold_last  = 1'b0;
    case (state)
      ST_IDLE: if (wreq && rdy) begin
        if (32'(cs_sel) < NUM_CS) begin
          accept    = 1'b1;
          state_nxt = ST_SETUP;
        end else begin
          reject = 1'b1;
        end
      end
      ST_SETUP: if (!pll_locked) abort = 1'b1;
        else if (cnt == CW'(CS_SETUP - 1)) begin
          setup_last = 1'b1;
          state_nxt  = ST_SHIFT;
        end
      ST_SHIFT: if (!pll_locked) abort = 1'b1;
        else if (shift_end) state_nxt = ST_HOLD;
      ST_HOLD: if (!pll_locked) abort = 1'b1;
        else if (cnt == CW'(CS_HOLD - 1)) begin
          hold_last = 1'b1;
          state_nxt = ST_GAP;
        end
      ST_GAP: if (cnt == CW'(CS_GAP - 1)) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (abort) state_nxt = ST_GAP;
  end

  always_comb begin
    tx_shl    = tx << 1;
    rx_shl    = rx << 1;
    rx_shl[0] = spi_miso;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt      <= '0;
      tx       <= '0;
      rx       <= '0;
      rdata    <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      rdy      <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      spi_sclk <= 1'b0;
      spi_csn  <= '1;
      spi_mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      rdy  <= (state_nxt == ST_IDLE) && pll_locked;
      if (state_nxt != state) cnt <= '0;
      else if (state != ST_IDLE && state != ST_SHIFT) cnt <= cnt + 1'b1;

      if (accept) begin
        tx       <= wdata;
        rx       <= '0;
        cpol_q   <= cpol;
        cpha_q   <= cpha;
        spi_csn  <= ~(NUM_CS'(1) << cs_sel);
        spi_sclk <= cpol;
        spi_mosi <= cpha ? 1'b0 : wdata[N_BIT-1];
      end
      if (reject) err <= 1'b1;

      // the sampling edge is the leading one for cpha=0 and the trailing one for cpha=1
      if (edge_stb) begin
        spi_sclk <= ~spi_sclk;
        if (lead ^ cpha_q) begin
          rx <= rx_shl;
        end else if (cpha_q) begin
          spi_mosi <= tx[N_BIT-1];
          tx       <= tx_shl;
        end else if (!last) begin
          spi_mosi <= tx_shl[N_BIT-1];
          tx       <= tx_shl;
        end
      end
      if (state == ST_SHIFT && state_nxt == ST_HOLD) spi_mosi <= 1'b0;

      if (hold_last) begin
        spi_csn <= '1;
        done    <= 1'b1;
        rdata   <= rx;
      end
      if (abort) begin
        spi_csn  <= '1;
        spi_sclk <= cpol_q;
        spi_mosi <= 1'b0;
        err      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// tb/tb_spi_master_multi.sv - directed bench for spi_master_multi (N_BIT=8, NUM_CS=3, CLK_DIV=2)
module tb_spi_master_multi;
  import spi_master_pkg::*;

  localparam int N_BIT = 8, NUM_CS = 3, CLK_DIV = 2, CS_SETUP = 2, CS_HOLD = 2, CS_GAP = 4;

  logic       clk = 1'b0, nrst = 1'b0, pll_locked = 1'b1, wreq = 1'b0, cpol = 1'b0, cpha = 1'b0;
  logic [7:0] wdata = '0;
  logic [1:0] cs_sel = '0;
  logic       rdy, done, err, spi_sclk, spi_mosi, spi_miso;
  logic [7:0] rdata;
  logic [2:0] spi_csn;

  logic       miso_mode = 1'b0;
  logic       sl_bit = 1'b0;
  logic [7:0] sl_data = '0;
  int         sl_idx = 7;

  int         checks = 0, errors = 0;
  int         edges, low_run, last_low, high_run, min_gap, falls, done_cnt, err_cnt, both_cnt;
  logic [7:0] mosi_cap;
  logic [2:0] csn_seen;
  logic       prev_sclk = 1'b0, prev_all1 = 1'b1, m_cpol = 1'b0, m_cpha = 1'b0, all1;

  always #5 clk = ~clk;

  spi_master_multi #(
    .N_BIT(N_BIT), .NUM_CS(NUM_CS), .CLK_DIV(CLK_DIV),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)
  ) dut (
    .clk(clk), .nrst(nrst), .pll_locked(pll_locked), .wreq(wreq), .wdata(wdata),
    .cs_sel(cs_sel), .cpol(cpol), .cpha(cpha), .rdy(rdy), .done(done), .err(err),
    .rdata(rdata), .spi_sclk(spi_sclk), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso)
  );

  assign spi_miso = miso_mode ? sl_bit : spi_mosi;

  // mode-3 slave: presents the next bit on each falling (leading) SCLK edge
  always @(negedge spi_sclk) begin
    if (miso_mode && spi_csn != 3'b111 && sl_idx >= 0) begin
      sl_bit = sl_data[sl_idx];
      sl_idx--;
    end
  end

  always @(negedge clk) begin
    all1 = (spi_csn == 3'b111);
    if (!all1) begin
      if (prev_all1) begin
        falls++;
        if (falls > 1 && high_run < min_gap) min_gap = high_run;
        low_run = 0;
      end
      low_run++;
      csn_seen = spi_csn;
      if (!prev_all1 && spi_sclk != prev_sclk) begin
        edges++;
        if ((spi_sclk != m_cpol) ^ m_cpha) mosi_cap = {mosi_cap[6:0], spi_mosi};
      end
    end else begin
      if (!prev_all1) begin
        last_low = low_run;
        high_run = 0;
      end
      high_run++;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
    prev_all1 = all1;
    prev_sclk = spi_sclk;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    edges = 0; low_run = 0; last_low = 0; high_run = 0; min_gap = 999;
    falls = 0; done_cnt = 0; err_cnt = 0; both_cnt = 0; mosi_cap = '0; csn_seen = 3'b111;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic [1:0] sel, input logic [1:0] mode);
    int n = 0;
    while (!rdy && n < 200) begin tick(1); n++; end
    check_eq("rdy_wait", 64'(rdy), 64'h1);
    wdata = d; cs_sel = sel; {cpol, cpha} = mode;
    m_cpol = mode[1]; m_cpha = mode[0];
    wreq = 1'b1;
    tick(1);
    wreq = 1'b0;
  endtask

  task automatic wait_end();
    int n = 0;
    while (!(done || err) && n < 300) begin tick(1); n++; end
    check_eq("end_wait", 64'(done || err), 64'h1);
  endtask

  initial begin
    int n;
    clear_mon();
    tick(3);
    check_eq("rst_csn", 64'(spi_csn), 64'h7);
    check_eq("rst_sclk", 64'(spi_sclk), 64'h0);
    check_eq("rst_mosi", 64'(spi_mosi), 64'h0);
    check_eq("rst_rdy", 64'(rdy), 64'h0);
    check_eq("rst_done_err", 64'({done, err}), 64'h0);
    check_eq("rst_rdata", 64'(rdata), 64'h0);
    nrst = 1'b1;

    // mode 0 loopback
    clear_mon();
    start_frame(8'hA5, 2'd0, MODE0);
    wait_end();
    check_eq("t1_done", 64'(done), 64'h1);
    check_eq("t1_rdata", 64'(rdata), 64'hA5);
    tick(2);
    check_eq("t1_mosi", 64'(mosi_cap), 64'hA5);
    check_eq("t1_csn_low", 64'(last_low), 64'd36);
    check_eq("t1_edges", 64'(edges), 64'd16);
    check_eq("t1_done_cnt", 64'(done_cnt), 64'd1);
    check_eq("t1_csn_seen", 64'(csn_seen), 64'h6);
    check_eq("t1_err_cnt", 64'(err_cnt), 64'd0);

    // mode 3 with independent MISO pattern
    miso_mode = 1'b1; sl_data = 8'hC3; sl_idx = 7;
    clear_mon();
    start_frame(8'h3C, 2'd0, MODE3);
    check_eq("t2_sclk_start", 64'(spi_sclk), 64'h1);
    wait_end();
    check_eq("t2_rdata", 64'(rdata), 64'hC3);
    tick(2);
    check_eq("t2_edges", 64'(edges), 64'd16);
    check_eq("t2_mosi", 64'(mosi_cap), 64'h3C);
    check_eq("t2_sclk_idle", 64'(spi_sclk), 64'h1);
    miso_mode = 1'b0;

    // valid then out-of-range chip select
    clear_mon();
    start_frame(8'h5A, 2'd1, MODE0);
    wait_end();
    tick(2);
    check_eq("t3_csn_sel1", 64'(csn_seen), 64'h5);
    check_eq("t3_rdata", 64'(rdata), 64'h5A);
    clear_mon();
    start_frame(8'hFF, 2'd3, MODE0);
    check_eq("t3_err", 64'(err), 64'h1);
    check_eq("t3_csn_idle", 64'(spi_csn), 64'h7);
    tick(3);
    check_eq("t3_falls", 64'(falls), 64'd0);
    check_eq("t3_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("t3_rdata_keep", 64'(rdata), 64'h5A);

    // pll_locked loss after five edges
    clear_mon();
    start_frame(8'hF0, 2'd0, MODE0);
    n = 0;
    while (edges < 5 && n < 200) begin tick(1); n++; end
    check_eq("t4_reach", 64'(edges), 64'd5);
    pll_locked = 1'b0;
    tick(1);
    check_eq("t4_csn", 64'(spi_csn), 64'h7);
    check_eq("t4_err", 64'(err), 64'h1);
    check_eq("t4_sclk", 64'(spi_sclk), 64'h0);
    pll_locked = 1'b1;
    tick(60);
    check_eq("t4_done_cnt", 64'(done_cnt), 64'd0);
    check_eq("t4_err_cnt", 64'(err_cnt), 64'd1);
    check_eq("t4_edges", 64'(edges), 64'd5);
    check_eq("t4_rdata", 64'(rdata), 64'h5A);

    // wreq held high across frames
    clear_mon();
    n = 0;
    while (!rdy && n < 200) begin tick(1); n++; end
    wdata = 8'h81; cs_sel = 2'd0; {cpol, cpha} = MODE0; m_cpol = 1'b0; m_cpha = 1'b0;
    wreq = 1'b1;
    n = 0;
    while (done_cnt < 3 && n < 400) begin tick(1); n++; end
    wreq = 1'b0;
    tick(12);
    check_eq("t5_done_cnt", 64'(done_cnt), 64'd3);
    check_eq("t5_falls", 64'(falls), 64'd3);
    check_eq("t5_min_gap", 64'(min_gap), 64'(CS_GAP + 1));
    check_eq("t5_csn_low", 64'(last_low), 64'd36);
    check_eq("t5_rdata", 64'(rdata), 64'h81);
    check_eq("t5_both", 64'(both_cnt), 64'd0);

    // asynchronous reset in the middle of a mode-3 frame
    clear_mon();
    start_frame(8'hFF, 2'd2, MODE3);
    n = 0;
    while (!(edges >= 2 && spi_sclk && spi_mosi) && n < 100) begin tick(1); n++; end
    check_eq("t6_reach", 64'(spi_sclk && spi_mosi), 64'h1);
    #2 nrst = 1'b0;
    #1;
    check_eq("t6_csn", 64'(spi_csn), 64'h7);
    check_eq("t6_sclk", 64'(spi_sclk), 64'h0);
    check_eq("t6_mosi", 64'(spi_mosi), 64'h0);
    check_eq("t6_rdy", 64'(rdy), 64'h0);
    check_eq("t6_rdata", 64'(rdata), 64'h0);
    tick(1);
    nrst = 1'b1;
    n = 0;
    while (!rdy && n < 5) begin tick(1); n++; end
    check_eq("t6_rdy_after", 64'(rdy), 64'h1);
    check_eq("t6_sclk_after", 64'(spi_sclk), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
